// File: rtl/ifetch_stage.sv
// Fetch stage: issues word reads to IMEM from the current PC, buffers returned
// instructions with their PCs in a small FIFO, and computes the next PC.
module ifetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              pc_cur,
  output logic [31:0]              pc_next,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [31:0]   r_instrMem [DEPTH];
  logic [31:0]   r_pcMem    [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [AW:0]   r_count;
  logic          r_reqValid;
  logic [31:0]   r_reqPc;

  logic [AW+1:0] w_occ;
  logic          w_popReq;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;

  assign imem_addr = {pc_cur[31:2], 2'b00};
  assign out_valid = (r_count != '0);
  assign out_instr = r_instrMem[r_rdPtr];
  assign out_pc    = r_pcMem[r_rdPtr];
  assign count     = r_count;

  // Credit check counts the in-flight read so a returning word always has a slot.
  assign w_occ    = {1'b0, r_count} + {{(AW+1){1'b0}}, r_reqValid};
  assign w_popReq = out_valid & out_ready;
  assign w_issue  = ~redirect & ((w_occ < (AW+2)'(DEPTH)) | w_popReq);
  assign w_pop    = w_popReq & ~redirect;
  assign w_push   = r_reqValid & ~redirect;

  always_comb begin
    pc_next = pc_cur;
    if (rst) begin
      pc_next = RESET_PC;
    end else if (redirect) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (w_issue) begin
      pc_next = pc_cur + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reqValid <= 1'b0;
      r_reqPc    <= '0;
    end else if (w_issue) begin
      r_reqValid <= 1'b1;
      r_reqPc    <= imem_addr;
    end else begin
      r_reqValid <= 1'b0;
    end
  end

  // Storage is cleared on reset so the head outputs are never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instrMem[i] <= '0;
        r_pcMem[i]    <= '0;
      end
    end else if (redirect) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_instrMem[r_wrPtr] <= imem_rdata;
        r_pcMem[r_wrPtr]    <= r_reqPc;
        r_wrPtr             <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Randomized bench for ifetch_stage: a queue-based reference model of the
// fetch pipeline drives pc_cur/IMEM and checks every output each cycle.
module tb_ifetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_cur = '0;
  logic [31:0] pc_next;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [$clog2(DEPTH):0] count;

  ifetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      mQueue[$];
  logic        mInFlight;
  logic [31:0] mInPc;
  logic [31:0] mPc;
  logic [31:0] mRdata;
  int          errCount = 0;
  int          checkCount = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Entered at a falling edge; holds reset for n cycles and checks the reset outputs.
  task automatic doReset(input int n);
    rst = 1'b1;
    pc_cur = RESET_PC;
    redirect = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("rstCount", 32'(count), 32'd0);
      checkOutput("rstValid", 32'(out_valid), 32'd0);
      checkOutput("rstInstr", out_instr, 32'd0);
      checkOutput("rstPc", out_pc, 32'd0);
      checkOutput("rstPcNext", pc_next, RESET_PC);
      @(negedge clk);
    end
    rst = 1'b0;
    mQueue.delete();
    mInFlight = 1'b0;
    mInPc = '0;
    mPc = RESET_PC;
    mRdata = '0;
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic ready);
    logic        expValid;
    logic        pop;
    logic        issue;
    int          occ;
    logic [31:0] expNext;
    redirect = redir;
    redirect_pc = rpc;
    out_ready = ready;
    pc_cur = mPc;
    imem_rdata = mRdata;
    #1;
    expValid = (mQueue.size() != 0);
    checkOutput("outValid", 32'(out_valid), 32'(expValid));
    if (expValid) begin
      checkOutput("outInstr", out_instr, mQueue[0].instr);
      checkOutput("outPc", out_pc, mQueue[0].pc);
    end
    checkOutput("count", 32'(count), 32'(mQueue.size()));
    pop = expValid && ready;
    occ = mQueue.size() + (mInFlight ? 1 : 0);
    issue = !redir && ((occ < DEPTH) || pop);
    expNext = redir ? {rpc[31:2], 2'b00} : (issue ? mPc + 32'd4 : mPc);
    checkOutput("pcNext", pc_next, expNext);
    checkOutput("imemAddr", imem_addr, {mPc[31:2], 2'b00});
    if (redir) begin
      mQueue.delete();
      mInFlight = 1'b0;
    end else begin
      if (pop) void'(mQueue.pop_front());
      if (mInFlight) mQueue.push_back('{instr: mRdata, pc: mInPc});
      mInFlight = issue;
      mInPc = {mPc[31:2], 2'b00};
    end
    mRdata = memWord({mPc[31:2], 2'b00});
    mPc = expNext;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    doReset(2);

    // Streaming with decode always ready.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1);

    // Backpressure from a fresh start until the FIFO saturates.
    doReset(1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0);
    pc_cur = mPc;
    out_ready = 1'b0;
    redirect = 1'b0;
    #1;
    checkOutput("satCount", 32'(count), 32'd4);
    checkOutput("holdPc", pc_next, 32'h10);

    // Single-cycle pop while full, then drain in order.
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1);

    // Redirect while full to a misaligned target.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h103, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1);

    // Back-to-back redirects: the last one wins.
    applyStimulus(1'b1, 32'h200, 1'b1);
    applyStimulus(1'b1, 32'h300, 1'b0);
    applyStimulus(1'b1, 32'h401, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1);

    // PC wraparound at the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFF4, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset between edges with three entries buffered.
    doReset(1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);
    pc_cur = mPc;
    imem_rdata = mRdata;
    out_ready = 1'b0;
    redirect = 1'b0;
    #1;
    checkOutput("preRstCount", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    checkOutput("asyncCount", 32'(count), 32'd0);
    checkOutput("asyncValid", 32'(out_valid), 32'd0);
    checkOutput("asyncPcNext", pc_next, RESET_PC);
    @(negedge clk);
    doReset(2);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
